// File: rtl/tick_pwm.sv
// rtl/tick_pwm.sv - tick-driven PWM with shadowed period/duty updated at frame boundaries
module tick_pwm #(
    parameter int WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             tick_i,
    input  logic             enable_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [WIDTH-1:0] cfg_period_i,
    input  logic [WIDTH-1:0] cfg_duty_i,
    output logic             pwm_o,
    output logic             cycle_o,
    output logic [WIDTH-1:0] phase_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic [WIDTH-1:0] period_a_q, period_a_d;
    logic [WIDTH-1:0] duty_a_q, duty_a_d;
    logic [WIDTH-1:0] period_s_q, period_s_d;
    logic [WIDTH-1:0] duty_s_q, duty_s_d;
    logic             pending_q, pending_d;
    logic             cycle_q, cycle_d;

    logic running;
    logic wrap;
    logic xfer;
    logic apply;

    // A frame ends when the last phase receives a tick; the shadow is applied
    // there, or immediately while idle. Pending is sampled pre-edge, so a
    // transfer coinciding with a wrap waits for the next boundary.
    assign running = (state_q != IDLE);
    assign wrap    = running && tick_i && (phase_q == period_a_q);
    assign xfer    = cfg_valid_i && !pending_q;
    assign apply   = pending_q && (wrap || (state_q == IDLE));

    // Run/stop sequencing and phase advance; enable held high keeps running.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cycle_d = wrap;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (enable_i) begin
                    state_d = RUN;
                end
            end
            RUN, DRAIN: begin
                if (tick_i) begin
                    phase_d = wrap ? '0 : (phase_q + ONE);
                end
                if (enable_i) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Shadow capture on handshake and promotion to the active pair.
    always_comb begin
        period_a_d = period_a_q;
        duty_a_d   = duty_a_q;
        period_s_d = period_s_q;
        duty_s_d   = duty_s_q;
        pending_d  = pending_q;
        if (apply) begin
            period_a_d = period_s_q;
            duty_a_d   = duty_s_q;
            pending_d  = 1'b0;
        end
        if (xfer) begin
            period_s_d = cfg_period_i;
            duty_s_d   = cfg_duty_i;
            pending_d  = 1'b1;
        end
    end

    // State registers; reset discards any pending configuration.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            period_a_q <= '1;
            duty_a_q   <= '0;
            period_s_q <= '0;
            duty_s_q   <= '0;
            pending_q  <= 1'b0;
            cycle_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            period_a_q <= period_a_d;
            duty_a_q   <= duty_a_d;
            period_s_q <= period_s_d;
            duty_s_q   <= duty_s_d;
            pending_q  <= pending_d;
            cycle_q    <= cycle_d;
        end
    end

    assign cfg_ready_o = !pending_q;
    assign cycle_o     = cycle_q;
    assign phase_o     = phase_q;
    assign pwm_o       = running && (phase_q < duty_a_q);

endmodule
